// File: rtl/game_timer.sv
// Purpose : in-game countdown sequencer; divides clk to a 1 s tick and counts
//           elapsed seconds through an IDLE/RUN/PAUSE/DONE state machine.
// Latency : all outputs registered; first sec_tick/elapsed update lands
//           TICK_DIV cycles after RUN entry from a cleared prescaler.
// Backpressure: none; control inputs are sampled every cycle, never stalled.
//
// Ports:
//   clk, rst_n     clock and asynchronous active-low reset
//   start          level; arms a new game from IDLE or DONE
//   pause          one-cycle pulse; toggles RUN <-> PAUSE
//   abort          level; forces IDLE and clears the count (highest priority)
//   penalty        one-cycle pulse; +1 s in RUN (only with TIMER_PENALTY_EN)
//   elapsed_time   seconds elapsed, 0..GAME_SEC, saturating
//   sec_tick       one-cycle pulse on every elapsed increment from the tick
//   time_up        one-cycle pulse when elapsed reaches GAME_SEC
//   running/paused state decodes; state is IDLE=0 RUN=1 PAUSE=2 DONE=3
//
// Optional feature macro: TIMER_PENALTY_EN (adds the penalty port and logic).
module game_timer #(
  parameter int TICK_DIV = 100_000_000,
  parameter int GAME_SEC = 30,
  parameter int CNT_W    = 27
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       pause,
  input  logic       abort,
`ifdef TIMER_PENALTY_EN
  input  logic       penalty,
`endif
  output logic [4:0] elapsed_time,
  output logic       sec_tick,
  output logic       time_up,
  output logic       running,
  output logic       paused,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] PRESC_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [4:0]       GAME_SEC_5 = 5'(GAME_SEC);
  localparam logic [5:0]       GAME_SEC_6 = 6'(GAME_SEC);

  state_e           state_q, state_d;
  logic [4:0]       elapsed_q, elapsed_d;
  logic [CNT_W-1:0] presc_q, presc_d;
  logic             sec_tick_q, sec_tick_d;
  logic             time_up_q, time_up_d;
  logic             running_q, running_d;
  logic             paused_q, paused_d;

  logic             tick_hit;
  logic             pen_hit;
  logic [1:0]       add_sec;
  logic [5:0]       sum_sec;
  logic [4:0]       sat_sec;

  assign tick_hit = (state_q == ST_RUN) && (presc_q == PRESC_LAST);

`ifdef TIMER_PENALTY_EN
  assign pen_hit = (state_q == ST_RUN) && penalty;
`else
  assign pen_hit = 1'b0;
`endif

  // A tick and a penalty in the same cycle add two seconds; the sum is one
  // bit wider so saturation at GAME_SEC can never wrap.
  assign add_sec = {1'b0, tick_hit} + {1'b0, pen_hit};
  assign sum_sec = {1'b0, elapsed_q} + {4'b0, add_sec};
  assign sat_sec = (sum_sec >= GAME_SEC_6) ? GAME_SEC_5 : sum_sec[4:0];

  always_comb begin
    state_d    = state_q;
    elapsed_d  = elapsed_q;
    presc_d    = presc_q;
    sec_tick_d = 1'b0;
    time_up_d  = 1'b0;

    if (abort) begin
      // Overrides any tick or timeout landing on the same edge.
      state_d   = ST_IDLE;
      elapsed_d = '0;
      presc_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_d   = ST_RUN;
            elapsed_d = '0;
            presc_d   = '0;
          end
        end
        ST_RUN: begin
          presc_d    = tick_hit ? '0 : presc_q + CNT_W'(1);
          elapsed_d  = sat_sec;
          sec_tick_d = tick_hit;
          // The edge that carries a pause pulse still performs the full RUN
          // update; reaching GAME_SEC wins over the pause request.
          if ((add_sec != 2'd0) && (sat_sec == GAME_SEC_5)) begin
            time_up_d = 1'b1;
            state_d   = ST_DONE;
          end else if (pause) begin
            state_d = ST_PAUSE;
          end
        end
        ST_PAUSE: begin
          if (pause) begin
            state_d = ST_RUN;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    running_d = (state_d == ST_RUN);
    paused_d  = (state_d == ST_PAUSE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      elapsed_q  <= '0;
      presc_q    <= '0;
      sec_tick_q <= 1'b0;
      time_up_q  <= 1'b0;
      running_q  <= 1'b0;
      paused_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      elapsed_q  <= elapsed_d;
      presc_q    <= presc_d;
      sec_tick_q <= sec_tick_d;
      time_up_q  <= time_up_d;
      running_q  <= running_d;
      paused_q   <= paused_d;
    end
  end

  assign state        = state_q;
  assign elapsed_time = elapsed_q;
  assign sec_tick     = sec_tick_q;
  assign time_up      = time_up_q;
  assign running      = running_q;
  assign paused       = paused_q;

endmodule

// File: tb/tb_game_timer.sv
// Purpose : self-checking bench for game_timer with a per-cycle scoreboard.
// Latency : expected outputs pushed when inputs are driven, popped 1 cycle later.
// Backpressure: n/a; stimulus is driven every cycle.
module tb_game_timer;

  localparam int TD = 4;
  localparam int GS = 30;
  localparam int CW = 27;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       pause;
  logic       abort;
  logic       penalty;
  logic [4:0] elapsed_time;
  logic       sec_tick;
  logic       time_up;
  logic       running;
  logic       paused;
  logic [1:0] state;

  game_timer #(
    .TICK_DIV(TD),
    .GAME_SEC(GS),
    .CNT_W   (CW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .pause       (pause),
    .abort       (abort),
`ifdef TIMER_PENALTY_EN
    .penalty     (penalty),
`endif
    .elapsed_time(elapsed_time),
    .sec_tick    (sec_tick),
    .time_up     (time_up),
    .running     (running),
    .paused      (paused),
    .state       (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] st;
    logic [4:0] el;
    logic       tk;
    logic       tu;
    logic       rn;
    logic       ps;
  } exp_t;

  exp_t exp_q[$];

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model state
  int m_st = 0;
  int m_el = 0;
  int m_pr = 0;

  // Running counts used by directed checks
  int n_ticks = 0;
  int n_tu    = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    m_st = 0;
    m_el = 0;
    m_pr = 0;
  endtask

  task automatic model_step(input logic s, input logic p, input logic a,
                            input logic pen, output exp_t e);
    int   inc;
    logic tk;
    logic tu;
    tk = 1'b0;
    tu = 1'b0;
    if (a) begin
      model_reset();
    end else if (m_st == 1) begin
      tk   = (m_pr == TD - 1);
      m_pr = tk ? 0 : m_pr + 1;
      inc  = (tk ? 1 : 0) + (pen ? 1 : 0);
      m_el = (m_el + inc >= GS) ? GS : m_el + inc;
      if (inc > 0 && m_el == GS) begin
        tu   = 1'b1;
        m_st = 3;
      end else if (p) begin
        m_st = 2;
      end
    end else if (m_st == 2) begin
      if (p) m_st = 1;
    end else if (s) begin
      m_st = 1;
      m_el = 0;
      m_pr = 0;
    end
    e.st = 2'(m_st);
    e.el = 5'(m_el);
    e.tk = tk;
    e.tu = tu;
    e.rn = (m_st == 1);
    e.ps = (m_st == 2);
  endtask

  // One clock of stimulus: drive at negedge, push expectation, compare #1
  // after the rising edge against the popped entry.
  task automatic step(input logic s, input logic p, input logic a, input logic pen);
    exp_t e;
    exp_t g;
    @(negedge clk);
    start   = s;
    pause   = p;
    abort   = a;
    penalty = pen;
    model_step(s, p, a, pen, e);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    g = exp_q.pop_front();
    chk("sb_state",    32'(state),        32'(g.st));
    chk("sb_elapsed",  32'(elapsed_time), 32'(g.el));
    chk("sb_sec_tick", 32'(sec_tick),     32'(g.tk));
    chk("sb_time_up",  32'(time_up),      32'(g.tu));
    chk("sb_running",  32'(running),      32'(g.rn));
    chk("sb_paused",   32'(paused),       32'(g.ps));
    if (sec_tick === 1'b1) n_ticks++;
    if (time_up === 1'b1)  n_tu++;
    start   = 1'b0;
    pause   = 1'b0;
    abort   = 1'b0;
    penalty = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_state"},   32'(state),        32'd0);
    chk({tag, "_elapsed"}, 32'(elapsed_time), 32'd0);
    chk({tag, "_tick"},    32'(sec_tick),     32'd0);
    chk({tag, "_timeup"},  32'(time_up),      32'd0);
    chk({tag, "_running"}, 32'(running),      32'd0);
    chk({tag, "_paused"},  32'(paused),       32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n   = 1'b0;
    start   = 1'b0;
    pause   = 1'b0;
    abort   = 1'b0;
    penalty = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Async reset mid-RUN with elapsed_time=7
    step(1'b1, 1'b0, 1'b0, 1'b0);
    idle(28);
    chk("t1_el7", 32'(elapsed_time), 32'd7);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("t1_async");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // Full game: start from IDLE, 120 cycles to timeout
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("t2_running", 32'(running), 32'd1);
    n_ticks = 0;
    n_tu    = 0;
    for (int i = 1; i <= 120; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0);
      if (i == 3) chk("t2_el_before_tick", 32'(elapsed_time), 32'd0);
      if (i == 4) begin
        chk("t2_el_first_tick", 32'(elapsed_time), 32'd1);
        chk("t2_first_sec_tick", 32'(sec_tick), 32'd1);
      end
    end
    chk("t2_el30",     32'(elapsed_time), 32'd30);
    chk("t2_done",     32'(state),        32'd3);
    chk("t2_time_up",  32'(time_up),      32'd1);
    chk("t2_coincide", 32'(sec_tick),     32'd1);
    chk("t2_ticks",    32'(n_ticks),      32'd30);
    chk("t2_tu_count", 32'(n_tu),         32'd1);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0);
      chk("t2_hold30", 32'(elapsed_time), 32'd30);
      chk("t2_hold_done", 32'(state), 32'd3);
    end

    // Restart from DONE
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("t4_restart_state", 32'(state),        32'd1);
    chk("t4_restart_el",    32'(elapsed_time), 32'd0);

    // Pause with prescaler at 2, hold 10 cycles, resume
    idle(2);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    chk("t3_paused", 32'(state), 32'd2);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0);
      chk("t3_frozen_el", 32'(elapsed_time), 32'd0);
      chk("t3_frozen_tick", 32'(sec_tick), 32'd0);
    end
    step(1'b0, 1'b1, 1'b0, 1'b0);
    chk("t3_resumed", 32'(state), 32'd1);
    chk("t3_no_tick_on_resume", 32'(sec_tick), 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("t3_tick_after_resume", 32'(sec_tick), 32'd1);
    chk("t3_el1", 32'(elapsed_time), 32'd1);

    // start held high while running does not restart
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0);
      chk("t4_no_restart", 32'(state), 32'd1);
    end
    chk("t4_kept_counting", 32'(elapsed_time), 32'd4);

    // abort on the 30th tick
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("t5_abort_idle", 32'(state), 32'd0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    idle(119);
    chk("t5_el29", 32'(elapsed_time), 32'd29);
    n_tu = 0;
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("t5_state",   32'(state),        32'd0);
    chk("t5_el",      32'(elapsed_time), 32'd0);
    chk("t5_time_up", 32'(time_up),      32'd0);
    chk("t5_tu_none", 32'(n_tu),         32'd0);

`ifdef TIMER_PENALTY_EN
    // Penalty at 29 forces timeout; penalty plus tick adds two
    step(1'b1, 1'b0, 1'b0, 1'b0);
    idle(116);
    chk("t6_el29", 32'(elapsed_time), 32'd29);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("t6_pen_el30",   32'(elapsed_time), 32'd30);
    chk("t6_pen_timeup", 32'(time_up),      32'd1);
    chk("t6_pen_done",   32'(state),        32'd3);
    chk("t6_pen_notick", 32'(sec_tick),     32'd0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    idle(23);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("t6_pen_tick_el7", 32'(elapsed_time), 32'd7);
    chk("t6_pen_tick_tk",  32'(sec_tick),     32'd1);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("t6_pen_in_pause", 32'(elapsed_time), 32'd7);
    step(1'b0, 1'b1, 1'b0, 1'b0);
`endif

    // Random control traffic against the model
    for (int i = 0; i < 300; i++) begin
      logic s;
      logic p;
      logic a;
      logic pen;
      s   = ($urandom_range(0, 15) == 0);
      p   = ($urandom_range(0, 7) == 0);
      a   = ($urandom_range(0, 63) == 0);
      pen = 1'b0;
`ifdef TIMER_PENALTY_EN
      pen = ($urandom_range(0, 9) == 0);
`endif
      step(s, p, a, pen);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
